// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU memory/IO port arbiter.
//   state_t      : arbiter FSM states (idle, issue, wait, respond)
//   REQ_IF/REQ_DM: requester ids latched with each access
//   RW_*/SEL_*   : port direction and memory/IO select values
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF   = 1'b0;
    localparam logic REQ_DM   = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic SEL_MEM  = 1'b0;
    localparam logic SEL_IO   = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory/IO port between instruction fetch (IF) and the
// load/store/IO unit (DM). One access is in flight at a time: IDLE/RESP pick a
// winner, ISSUE pulses mem_en, WAIT covers the port read latency, RESP reports.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req/if_addr                   fetch request (always a memory read)
//   if_gnt/if_rvalid/if_rdata        fetch accept pulse, data-valid pulse, data
//   dm_req/dm_rw/dm_memio/dm_addr/dm_wdata   data-side request and command
//   dm_gnt/dm_done/dm_rdata          data-side accept pulse, done pulse, read data
//   mem_en/mem_rw/mem_memio/mem_addr/mem_wdata  port command (mem_en one-cycle pulse)
//   mem_rdata                        port read data, valid MEM_LAT cycles after mem_en
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic              dm_memio,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_rw,
    output logic              mem_memio,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef struct packed {
        logic              id;
        logic              rw;
        logic              memio;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state_q, state_nxt;
    logic [LAT_W-1:0]  lat_q, lat_nxt;
    logic [STV_W-1:0]  starve_q, starve_nxt;
    cmd_t              cmd_q, cmd_nxt;

    logic              mem_en_nxt;
    logic              if_gnt_nxt, dm_gnt_nxt;
    logic              if_rvalid_nxt, dm_done_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;
    logic              if_pick, dm_pick;

    // Port command comes straight from the latched command register, so it
    // holds its last value between accesses.
    assign mem_rw    = cmd_q.rw;
    assign mem_memio = cmd_q.memio;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    // DM has priority unless IF has lost STARVE_MAX times in a row.
    assign if_pick = if_req && (!dm_req || (starve_q == STV_MAX));
    assign dm_pick = dm_req && !if_pick;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            starve_q  <= '0;
            cmd_q     <= '0;
            mem_en    <= 1'b0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state_q   <= state_nxt;
            lat_q     <= lat_nxt;
            starve_q  <= starve_nxt;
            cmd_q     <= cmd_nxt;
            mem_en    <= mem_en_nxt;
            if_gnt    <= if_gnt_nxt;
            dm_gnt    <= dm_gnt_nxt;
            if_rvalid <= if_rvalid_nxt;
            dm_done   <= dm_done_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
        end
    end

    // Next-state, arbitration, latency count and response generation.
    always_comb begin
        state_nxt     = state_q;
        lat_nxt       = lat_q;
        starve_nxt    = starve_q;
        cmd_nxt       = cmd_q;
        mem_en_nxt    = 1'b0;
        if_gnt_nxt    = 1'b0;
        dm_gnt_nxt    = 1'b0;
        if_rvalid_nxt = 1'b0;
        dm_done_nxt   = 1'b0;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (if_pick) begin
                    state_nxt     = ST_ISSUE;
                    mem_en_nxt    = 1'b1;
                    if_gnt_nxt    = 1'b1;
                    starve_nxt    = '0;
                    cmd_nxt.id    = REQ_IF;
                    cmd_nxt.rw    = RW_READ;
                    cmd_nxt.memio = SEL_MEM;
                    cmd_nxt.addr  = if_addr;
                    cmd_nxt.wdata = '0;
                end else if (dm_pick) begin
                    state_nxt     = ST_ISSUE;
                    mem_en_nxt    = 1'b1;
                    dm_gnt_nxt    = 1'b1;
                    cmd_nxt.id    = REQ_DM;
                    cmd_nxt.rw    = dm_rw;
                    cmd_nxt.memio = dm_memio;
                    cmd_nxt.addr  = dm_addr;
                    cmd_nxt.wdata = dm_wdata;
                    // Saturating count of IF losses.
                    if (if_req && (starve_q != STV_MAX)) begin
                        starve_nxt = starve_q + STV_W'(1);
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                state_nxt = ST_WAIT;
                lat_nxt   = LAT_LOAD;
            end

            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_nxt = ST_RESP;
                    if (cmd_q.id == REQ_IF) begin
                        if_rvalid_nxt = 1'b1;
                        if_rdata_nxt  = mem_rdata;
                    end else begin
                        dm_done_nxt = 1'b1;
                        if (cmd_q.rw == RW_READ) begin
                            dm_rdata_nxt = mem_rdata;
                        end
                    end
                end else begin
                    lat_nxt = lat_q - LAT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with MEM_LAT=1 (scoreboarded
// read data) and one with MEM_LAT=3 for the long-latency timing.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance with MEM_LAT=1
    logic        if_req, dm_req, dm_rw, dm_memio;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_done;
    logic [15:0] if_rdata, dm_rdata;
    logic        mem_en, mem_rw, mem_memio;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // Instance with MEM_LAT=3
    logic        if_req_b, dm_req_b, dm_rw_b, dm_memio_b;
    logic [15:0] if_addr_b, dm_addr_b, dm_wdata_b;
    logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_done_b;
    logic [15:0] if_rdata_b, dm_rdata_b;
    logic        mem_en_b, mem_rw_b, mem_memio_b;
    logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_memio(dm_memio), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_memio(mem_memio), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(3)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req_b), .dm_rw(dm_rw_b), .dm_memio(dm_memio_b), .dm_addr(dm_addr_b),
        .dm_wdata(dm_wdata_b), .dm_gnt(dm_gnt_b), .dm_done(dm_done_b), .dm_rdata(dm_rdata_b),
        .mem_en(mem_en_b), .mem_rw(mem_rw_b), .mem_memio(mem_memio_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // Port model: data is valid only in the cycle MEM_LAT after the mem_en cycle.
    function automatic logic [15:0] rd_val(input logic [15:0] a, input logic io);
        return io ? (a | 16'hFF00) : (a ^ 16'h1FFC);
    endfunction

    int unsigned cnt_a, cnt_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            if (mem_en) cnt_a <= 1;
            else if (cnt_a != 0) cnt_a <= cnt_a - 1;
            if (mem_en_b) cnt_b <= 3;
            else if (cnt_b != 0) cnt_b <= cnt_b - 1;
        end
    end
    assign mem_rdata   = (cnt_a == 1) ? rd_val(mem_addr, mem_memio) : 16'hDEAD;
    assign mem_rdata_b = (cnt_b == 1) ? rd_val(mem_addr_b, mem_memio_b) : 16'hDEAD;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the MEM_LAT=1 instance.
    typedef struct {
        logic        wr;
        logic [15:0] data;
    } exp_t;
    exp_t        if_q[$];
    exp_t        dm_q[$];
    logic [15:0] dm_last = 16'h0000;
    logic        en_prev = 1'b0;
    int          en_count = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) check("if_unexpected_rvalid", 1, 0);
                else begin
                    check("if_rdata", if_rdata, if_q[0].data);
                    void'(if_q.pop_front());
                end
            end
            if (dm_done) begin
                if (dm_q.size() == 0) check("dm_unexpected_done", 1, 0);
                else begin
                    if (dm_q[0].wr) check("dm_rdata_hold_on_write", dm_rdata, dm_last);
                    else begin
                        check("dm_rdata", dm_rdata, dm_q[0].data);
                        dm_last <= dm_q[0].data;
                    end
                    void'(dm_q.pop_front());
                end
            end
            if (mem_en) begin
                check("mem_en_with_gnt", 32'(if_gnt | dm_gnt), 1);
                check("mem_en_single_cycle", 32'(en_prev), 0);
            end
            en_prev  <= mem_en;
            en_count <= en_count + (mem_en ? 1 : 0);
        end else begin
            en_prev <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant on the MEM_LAT=1 instance.
    task automatic wait_gnt(input string tag, output logic got_if, output logic got_dm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(if_gnt || dm_gnt) && n < 20);
        if (!(if_gnt || dm_gnt)) check({tag, "_gnt_timeout"}, 0, 1);
        got_if = if_gnt;
        got_dm = dm_gnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic got_if, got_dm, dm_pend;
    int   dm_wins, guard, en0;

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_rw = 0; dm_memio = 0; dm_addr = 0; dm_wdata = 0;
        if_req_b = 0; if_addr_b = 0; dm_req_b = 0; dm_rw_b = 0; dm_memio_b = 0;
        dm_addr_b = 0; dm_wdata_b = 0;
        #12;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_gnts", 32'({if_gnt, dm_gnt}), 0);
        check("rst_resp", 32'({if_rvalid, dm_done}), 0);
        check("rst_rdata", 32'({if_rdata, dm_rdata}), 0);
        check("rst_cmd", 32'({mem_rw, mem_memio, mem_addr}), 0);
        check("rst_b_outputs", 32'({mem_en_b, if_gnt_b, if_rvalid_b, mem_addr_b}), 0);
        #10;
        rst_n = 1'b1;
        step();

        // IF fetch, MEM_LAT=1
        if_req = 1; if_addr = 16'h0003;
        if_q.push_back('{wr: 1'b0, data: 16'h1FFF});
        step();
        check("t1_if_gnt", 32'(if_gnt), 1);
        check("t1_dm_gnt", 32'(dm_gnt), 0);
        check("t1_mem_en", 32'(mem_en), 1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0003);
        check("t1_mem_rw", 32'({mem_rw, mem_memio}), 0);
        if_req = 0;
        step();
        check("t1_c2_en_rvalid", 32'({mem_en, if_rvalid}), 0);
        step();
        check("t1_c3_rvalid", 32'(if_rvalid), 1);
        check("t1_c3_dm_done", 32'(dm_done), 0);
        step();
        check("t1_c4_rvalid_low", 32'(if_rvalid), 0);
        step();

        // DM IO read
        dm_req = 1; dm_rw = 0; dm_memio = 1; dm_addr = 16'h00FF;
        dm_q.push_back('{wr: 1'b0, data: 16'hFFFF});
        step();
        check("t4_dm_gnt", 32'(dm_gnt), 1);
        check("t4_mem_memio", 32'(mem_memio), 1);
        check("t4_mem_addr", 32'(mem_addr), 32'h00FF);
        dm_req = 0;
        step();
        step();
        check("t4_dm_done", 32'(dm_done), 1);
        step();

        // DM memory write
        en0 = en_count;
        dm_req = 1; dm_rw = 1; dm_memio = 0; dm_addr = 16'h0708; dm_wdata = 16'hABCD;
        dm_q.push_back('{wr: 1'b1, data: 16'h0000});
        step();
        check("t2_dm_gnt", 32'(dm_gnt), 1);
        check("t2_mem_en_rw", 32'({mem_en, mem_rw, mem_memio}), 32'b110);
        check("t2_mem_addr", 32'(mem_addr), 32'h0708);
        check("t2_mem_wdata", 32'(mem_wdata), 32'hABCD);
        dm_req = 0; dm_rw = 0;
        step();
        check("t2_c2_done_low", 32'(dm_done), 0);
        step();
        check("t2_c3_done", 32'(dm_done), 1);
        check("t2_rdata_kept", 32'(dm_rdata), 32'hFFFF);
        step();
        check("t2_cmd_hold", 32'({mem_en, mem_rw, mem_addr}), 32'h10708);
        step();
        check("t2_one_en_pulse", en_count - en0, 1);

        // Both requesting: DM wins STARVE_MAX times, then IF
        if_req = 1; if_addr = 16'h0100;
        if_q.push_back('{wr: 1'b0, data: rd_val(16'h0100, 1'b0)});
        dm_wins = 0; dm_pend = 0; got_if = 0; guard = 0;
        while (!got_if && guard < 6) begin
            guard++;
            if (!dm_pend) begin
                dm_req = 1; dm_rw = 0; dm_memio = 0; dm_addr = 16'h0200 + 16'(dm_wins);
                dm_q.push_back('{wr: 1'b0, data: rd_val(dm_addr, 1'b0)});
                dm_pend = 1;
            end
            wait_gnt("t3", got_if, got_dm);
            if (got_dm) begin
                dm_wins++;
                dm_pend = 0;
                dm_req = 0;
            end
        end
        check("t3_dm_wins", dm_wins, 3);
        check("t3_if_won", 32'(got_if), 1);
        if_req = 0;
        wait_gnt("t3_dm_pending", got_if, got_dm);
        check("t3_dm_pending_served", 32'(got_dm), 1);
        dm_req = 0;
        // Starve count cleared: with both asking again DM goes first
        if_req = 1; if_addr = 16'h0101;
        if_q.push_back('{wr: 1'b0, data: rd_val(16'h0101, 1'b0)});
        dm_req = 1; dm_addr = 16'h0300;
        dm_q.push_back('{wr: 1'b0, data: rd_val(16'h0300, 1'b0)});
        wait_gnt("t3_clear", got_if, got_dm);
        check("t3_cleared_dm_first", 32'({got_if, got_dm}), 32'b01);
        dm_req = 0;
        wait_gnt("t3_if_next", got_if, got_dm);
        check("t3_if_next", 32'(got_if), 1);
        if_req = 0;
        repeat (5) step();

        // Reset during WAIT
        if_req = 1; if_addr = 16'h0010;
        step();
        check("t6_if_gnt", 32'(if_gnt), 1);
        if_req = 0;
        step();
        rst_n = 1'b0;
        #1;
        check("t6_abort_en_gnt", 32'({mem_en, if_gnt, dm_gnt}), 0);
        check("t6_abort_resp", 32'({if_rvalid, dm_done}), 0);
        check("t6_abort_regs", 32'({if_rdata, mem_addr}), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("t6_no_rvalid", 32'(if_rvalid), 0);
        if_req = 1; if_addr = 16'h0003;
        if_q.push_back('{wr: 1'b0, data: 16'h1FFF});
        step();
        check("t6_new_gnt", 32'({if_gnt, mem_en}), 32'b11);
        check("t6_new_addr", 32'(mem_addr), 32'h0003);
        if_req = 0;
        step();
        step();
        check("t6_new_rvalid", 32'(if_rvalid), 1);
        step();

        // MEM_LAT=3 instance: three WAIT cycles, back-to-back request in RESP
        if_req_b = 1; if_addr_b = 16'h0020;
        step();
        check("t5_gnt", 32'({if_gnt_b, mem_en_b}), 32'b11);
        if_req_b = 0;
        for (int c = 2; c <= 4; c++) begin
            step();
            check("t5_wait", 32'({if_rvalid_b, mem_en_b}), 0);
        end
        step();
        check("t5_rvalid_c5", 32'(if_rvalid_b), 1);
        check("t5_rdata", 32'(if_rdata_b), 32'h1FDC);
        if_req_b = 1; if_addr_b = 16'h0021;
        step();
        check("t5_b2b_gnt", 32'({if_gnt_b, mem_en_b}), 32'b11);
        check("t5_b2b_addr", 32'(mem_addr_b), 32'h0021);
        if_req_b = 0;
        repeat (3) step();
        step();
        check("t5_b2b_rvalid", 32'(if_rvalid_b), 1);
        check("t5_b2b_rdata", 32'(if_rdata_b), 32'h1FDD);

        repeat (4) step();
        check("if_q_drained", if_q.size(), 0);
        check("dm_q_drained", dm_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
